vend_ctrl: RTL and testbench

//  Parametrised vending controller; next generation of the single-price chocolate FSM.

---
 rtl/vend_pkg.sv | 37 +++
 rtl/vend_if.sv | 35 +++
 rtl/vend_coin_dec.sv | 31 +++
 rtl/vend_ctrl.sv | 128 ++++++++++++
 tb/tb_vend_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : vend_pkg
// Purpose : Shared types and constants for the vending controller: FSM state
//           encoding, coin code values and a coin-code to value helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package vend_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2
  } state_t;

  localparam logic [1:0] c_code_v0  = 2'b00;
  localparam logic [1:0] c_code_v1  = 2'b01;
  localparam logic [1:0] c_code_v2  = 2'b10;
  localparam logic [1:0] c_code_bad = 2'b11;

  // Unit value of a coin code; the invalid code is worth nothing.
  function automatic int unsigned coin_value(input logic [1:0] code,
                                             input int unsigned v0,
                                             input int unsigned v1,
                                             input int unsigned v2);
    case (code)
      c_code_v0: return v0;
      c_code_v1: return v1;
      c_code_v2: return v2;
      default:   return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : vend_if
// Purpose : Bundle between coin-validator front end / actuators (master) and
//           the vending controller (slave).
// Ports   : coin_valid, coin_code, cancel          master -> slave
//           coin_accept, coin_reject, vend,
//           change_pulse, busy, credit              slave  -> master
// Rev     : 1.0  initial release
// ============================================================================
interface vend_if #(
  parameter int CREDIT_W = 4
);
  logic                coin_valid;
  logic [1:0]          coin_code;
  logic                cancel;
  logic                coin_accept;
  logic                coin_reject;
  logic                vend;
  logic                change_pulse;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin_valid, coin_code, cancel,
    input  coin_accept, coin_reject, vend, change_pulse, busy, credit
  );

  modport slave (
    input  coin_valid, coin_code, cancel,
    output coin_accept, coin_reject, vend, change_pulse, busy, credit
  );
endinterface
`default_nettype wire

// File: rtl/vend_coin_dec.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : vend_coin_dec
// Purpose : Combinational coin decoder: denomination code -> unit value plus
//           a validity flag. Code 2'b11 is never valid.
// Ports   : i_code   in  2         denomination code
//           o_value  out CREDIT_W  coin value (0 when invalid)
//           o_valid  out 1         code is a legal denomination
// Rev     : 1.0  initial release
// ============================================================================
module vend_coin_dec
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int VAL0     = 1,
  parameter int VAL1     = 2,
  parameter int VAL2     = 5
) (
  input  wire logic [1:0]          i_code,
  output logic      [CREDIT_W-1:0] o_value,
  output logic                     o_valid
);

  always_comb begin
    o_value = CREDIT_W'(coin_value(i_code, VAL0, VAL1, VAL2));
    o_valid = (i_code != c_code_bad);
  end

endmodule
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : vend_ctrl
// Purpose : Parametrised vending controller. Accumulates coin credit, issues a
//           single vend pulse at PRICE and pays back change / refunds one
//           unit per cycle.
// Ports   : clk    in  1      rising-edge clock
//           rst_n  in  1      asynchronous active-low reset
//           bus    slave      coin_valid/coin_code/cancel in;
//                             coin_accept/coin_reject/vend/change_pulse/
//                             busy/credit out (all registered or Moore)
// Rev     : 1.0  initial release
// ============================================================================
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 5,
  parameter int MAX_CREDIT = 9,
  parameter int CREDIT_W   = 4,
  parameter int VAL0       = 1,
  parameter int VAL1       = 2,
  parameter int VAL2       = 5
) (
  input  wire logic clk,
  input  wire logic rst_n,
  vend_if.slave     bus
);

  localparam logic [CREDIT_W:0]   c_max_credit = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] c_price      = CREDIT_W'(PRICE);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                r_accept;
  logic                r_reject;
  logic                w_accept_nxt;
  logic                w_reject_nxt;
  logic [CREDIT_W-1:0] w_coin_val;
  logic                w_coin_ok;
  logic [CREDIT_W:0]   w_sum;

  vend_coin_dec #(
    .CREDIT_W (CREDIT_W),
    .VAL0     (VAL0),
    .VAL1     (VAL1),
    .VAL2     (VAL2)
  ) u_coin_dec (
    .i_code  (bus.coin_code),
    .o_value (w_coin_val),
    .o_valid (w_coin_ok)
  );

  // One extra bit so the overflow test cannot wrap.
  assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_COLLECT;
      r_credit <= '0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_accept <= w_accept_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_accept_nxt = 1'b0;
    w_reject_nxt = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (bus.cancel) begin
          // Cancel has priority: a coin arriving alongside it is refused.
          w_reject_nxt = bus.coin_valid;
          if (r_credit != '0) begin
            w_state_nxt = ST_CHANGE;
          end
        end else if (bus.coin_valid) begin
          if (w_coin_ok && (w_sum <= c_max_credit)) begin
            w_accept_nxt = 1'b1;
            w_credit_nxt = w_sum[CREDIT_W-1:0];
            if (w_sum >= {1'b0, c_price}) begin
              w_state_nxt = ST_VEND;
            end
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      ST_VEND: begin
        w_reject_nxt = bus.coin_valid;
        w_credit_nxt = (r_credit >= c_price) ? (r_credit - c_price) : '0;
        // Any remainder, even one >= PRICE, is paid out rather than re-vended.
        w_state_nxt  = (w_credit_nxt != '0) ? ST_CHANGE : ST_COLLECT;
      end
      ST_CHANGE: begin
        w_reject_nxt = bus.coin_valid;
        if (r_credit > CREDIT_W'(1)) begin
          w_credit_nxt = r_credit - CREDIT_W'(1);
        end else begin
          w_credit_nxt = '0;
          w_state_nxt  = ST_COLLECT;
        end
      end
      default: begin
        w_credit_nxt = '0;
        w_state_nxt  = ST_COLLECT;
      end
    endcase
  end

  assign bus.coin_accept  = r_accept;
  assign bus.coin_reject  = r_reject;
  assign bus.vend         = (r_state == ST_VEND);
  assign bus.change_pulse = (r_state == ST_CHANGE);
  assign bus.busy         = (r_state != ST_COLLECT);
  assign bus.credit       = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_vend_ctrl
// Purpose : Self-checking bench for vend_ctrl. Instance A uses the default
//           pricing (PRICE=5); instance B uses PRICE=9 so a credit of 8 can be
//           held and the overflow / max-credit boundary can be reached.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vend_ctrl;

  typedef struct packed {
    logic       acc;   // 1: accept expected, 0: reject expected
    logic [3:0] cred;  // credit expected while the pulse is high
    logic       chk;   // compare credit
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vend_if #(.CREDIT_W(4)) bus_a ();
  vend_if #(.CREDIT_W(4)) bus_b ();

  vend_ctrl #(
    .PRICE(5), .MAX_CREDIT(9), .CREDIT_W(4), .VAL0(1), .VAL1(2), .VAL2(5)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  vend_ctrl #(
    .PRICE(9), .MAX_CREDIT(9), .CREDIT_W(4), .VAL0(1), .VAL1(2), .VAL2(5)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt_vend[2];
  int   cnt_chg[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers: every accept/reject pulse pops one expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.vend)         cnt_vend[0]++;
      if (bus_a.change_pulse) cnt_chg[0]++;
      if (bus_a.coin_accept || bus_a.coin_reject) begin
        check_val("a_coin_pending", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          e_a = q_a.pop_front();
          check_val("a_coin_result", 32'({bus_a.coin_accept, bus_a.coin_reject}),
                    32'({e_a.acc, ~e_a.acc}));
          if (e_a.chk) check_val("a_coin_credit", 32'(bus_a.credit), 32'(e_a.cred));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.vend)         cnt_vend[1]++;
      if (bus_b.change_pulse) cnt_chg[1]++;
      if (bus_b.coin_accept || bus_b.coin_reject) begin
        check_val("b_coin_pending", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          e_b = q_b.pop_front();
          check_val("b_coin_result", 32'({bus_b.coin_accept, bus_b.coin_reject}),
                    32'({e_b.acc, ~e_b.acc}));
          if (e_b.chk) check_val("b_coin_credit", 32'(bus_b.credit), 32'(e_b.cred));
        end
      end
    end
  end

  task automatic set_in(input int s, input logic v, input logic [1:0] c, input logic k);
    if (s == 0) begin
      bus_a.coin_valid = v; bus_a.coin_code = c; bus_a.cancel = k;
    end else begin
      bus_b.coin_valid = v; bus_b.coin_code = c; bus_b.cancel = k;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one coin strobe (optionally with cancel) and queue its expected answer.
  task automatic coin_nogap(input int s, input logic [1:0] code, input logic k,
                            input logic acc, input logic [3:0] cred, input logic chk);
    exp_t e;
    e = '{acc: acc, cred: cred, chk: chk};
    if (s == 0) q_a.push_back(e); else q_b.push_back(e);
    set_in(s, 1'b1, code, k);
    cycle();
    set_in(s, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic coin(input int s, input logic [1:0] code, input logic k,
                      input logic acc, input logic [3:0] cred, input logic chk);
    coin_nogap(s, code, k, acc, cred, chk);
    cycle();
  endtask

  task automatic cancel_only(input int s);
    set_in(s, 1'b0, 2'b00, 1'b1);
    cycle();
    set_in(s, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic wait_idle(input int s, input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (((s == 0) ? bus_a.busy : bus_b.busy) == 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(done), 32'd1);
  endtask

  task automatic reset_cnt(input int s);
    cnt_vend[s] = 0;
    cnt_chg[s]  = 0;
  endtask

  function automatic logic [8:0] outs(input int s);
    if (s == 0)
      return {bus_a.coin_accept, bus_a.coin_reject, bus_a.vend, bus_a.change_pulse,
              bus_a.busy, bus_a.credit};
    return {bus_b.coin_accept, bus_b.coin_reject, bus_b.vend, bus_b.change_pulse,
            bus_b.busy, bus_b.credit};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    set_in(0, 1'b0, 2'b00, 1'b0);
    set_in(1, 1'b0, 2'b00, 1'b0);
    reset_cnt(0);
    reset_cnt(1);
    #22 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_outs_a", 32'(outs(0)), 32'd0);
    check_val("rst_outs_b", 32'(outs(1)), 32'd0);

    // Cancel with zero credit does nothing.
    cancel_only(0);
    wait_idle(0, "t0_idle");
    check_val("t0_change", 32'(cnt_chg[0]), 32'd0);
    check_val("t0_credit", 32'(bus_a.credit), 32'd0);

    // 1 + 2 + 2 reaches the price exactly.
    reset_cnt(0);
    coin(0, 2'b00, 1'b0, 1'b1, 4'd1, 1'b1);
    coin(0, 2'b01, 1'b0, 1'b1, 4'd3, 1'b1);
    coin_nogap(0, 2'b01, 1'b0, 1'b1, 4'd5, 1'b1);
    @(negedge clk);
    check_val("t1_vend_now", 32'(bus_a.vend), 32'd1);
    wait_idle(0, "t1_idle");
    check_val("t1_vend_cnt", 32'(cnt_vend[0]), 32'd1);
    check_val("t1_change", 32'(cnt_chg[0]), 32'd0);
    check_val("t1_credit", 32'(bus_a.credit), 32'd0);

    // 2 then 5: credit 7, vend, two units of change.
    reset_cnt(0);
    coin(0, 2'b01, 1'b0, 1'b1, 4'd2, 1'b1);
    coin_nogap(0, 2'b10, 1'b0, 1'b1, 4'd7, 1'b1);
    @(negedge clk);
    check_val("t2_vend_now", 32'(bus_a.vend), 32'd1);
    wait_idle(0, "t2_idle");
    check_val("t2_vend_cnt", 32'(cnt_vend[0]), 32'd1);
    check_val("t2_change", 32'(cnt_chg[0]), 32'd2);
    check_val("t2_credit", 32'(bus_a.credit), 32'd0);

    // 2 + 2 then cancel: full refund, no vend.
    reset_cnt(0);
    coin(0, 2'b01, 1'b0, 1'b1, 4'd2, 1'b1);
    coin(0, 2'b01, 1'b0, 1'b1, 4'd4, 1'b1);
    cancel_only(0);
    wait_idle(0, "t3_idle");
    check_val("t3_vend_cnt", 32'(cnt_vend[0]), 32'd0);
    check_val("t3_change", 32'(cnt_chg[0]), 32'd4);
    check_val("t3_credit", 32'(bus_a.credit), 32'd0);

    // Coin during CHANGE is refused and the refund count is unchanged.
    reset_cnt(0);
    coin(0, 2'b01, 1'b0, 1'b1, 4'd2, 1'b1);
    coin(0, 2'b01, 1'b0, 1'b1, 4'd4, 1'b1);
    cancel_only(0);
    coin_nogap(0, 2'b00, 1'b0, 1'b0, 4'd3, 1'b1);
    wait_idle(0, "t5_idle");
    check_val("t5_change", 32'(cnt_chg[0]), 32'd4);
    check_val("t5_vend_cnt", 32'(cnt_vend[0]), 32'd0);
    check_val("t5_credit", 32'(bus_a.credit), 32'd0);

    // Instance B (PRICE=9): build credit 8, then overflow / bad code / cancel+coin.
    reset_cnt(1);
    coin(1, 2'b10, 1'b0, 1'b1, 4'd5, 1'b1);
    coin(1, 2'b01, 1'b0, 1'b1, 4'd7, 1'b1);
    coin(1, 2'b00, 1'b0, 1'b1, 4'd8, 1'b1);
    coin(1, 2'b01, 1'b0, 1'b0, 4'd8, 1'b1);
    coin(1, 2'b11, 1'b0, 1'b0, 4'd8, 1'b1);
    coin_nogap(1, 2'b00, 1'b1, 1'b0, 4'd8, 1'b1);
    wait_idle(1, "t4_idle");
    check_val("t4_change", 32'(cnt_chg[1]), 32'd8);
    check_val("t4_vend_cnt", 32'(cnt_vend[1]), 32'd0);
    check_val("t4_credit", 32'(bus_b.credit), 32'd0);

    // Instance B: credit lands exactly on MAX_CREDIT == PRICE.
    reset_cnt(1);
    coin(1, 2'b10, 1'b0, 1'b1, 4'd5, 1'b1);
    coin(1, 2'b01, 1'b0, 1'b1, 4'd7, 1'b1);
    coin_nogap(1, 2'b01, 1'b0, 1'b1, 4'd9, 1'b1);
    @(negedge clk);
    check_val("t4b_vend_now", 32'(bus_b.vend), 32'd1);
    wait_idle(1, "t4b_idle");
    check_val("t4b_vend_cnt", 32'(cnt_vend[1]), 32'd1);
    check_val("t4b_change", 32'(cnt_chg[1]), 32'd0);

    // Asynchronous reset in the middle of a refund.
    reset_cnt(0);
    coin(0, 2'b01, 1'b0, 1'b1, 4'd2, 1'b1);
    coin(0, 2'b01, 1'b0, 1'b1, 4'd4, 1'b1);
    cancel_only(0);
    @(negedge clk);
    check_val("t6_in_change", 32'(bus_a.change_pulse), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_outs", 32'(outs(0)), 32'd0);
    #3 rst_n = 1'b1;
    reset_cnt(0);
    @(negedge clk);
    coin_nogap(0, 2'b10, 1'b0, 1'b1, 4'd5, 1'b1);
    wait_idle(0, "t6_idle");
    check_val("t6_vend_cnt", 32'(cnt_vend[0]), 32'd1);
    check_val("t6_change", 32'(cnt_chg[0]), 32'd0);
    check_val("t6_credit", 32'(bus_a.credit), 32'd0);

    cycle();
    cycle();
    check_val("q_a_empty", 32'(q_a.size()), 32'd0);
    check_val("q_b_empty", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
